traffic_sensor_conditioner: RTL and testbench

Front-end stage feeding traffic_light_controller. It conditions raw vehicle loop-detector levels and the pedestrian push-button, and produces the controller's ns_density, ew_density and ped_req inputs. Each lane counts debounced vehicle arrivals over a fixed window and applies hysteresis to produce its density flag. The pedestrian press is latched until the controller's ped_signal acknowledges service.

---
 rtl/traffic_sensor_conditioner.sv | 147 ++++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
// Conditions loop detectors and ped button into density flags and a latched ped request.
// Latency: raw level to debounced change in DEBOUNCE+2 edges; density updates only at window ends.
// No backpressure. `define SENSOR_FAULT_EN adds per-lane stuck-sensor fault outputs.
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int WINDOW   = 100,
  parameter int HIGH_TH  = 6,
  parameter int LOW_TH   = 3,
  parameter int CNT_W    = 8
`ifdef SENSOR_FAULT_EN
  , parameter int STUCK_TIME = 500
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic ns_sensor,
  input  logic ew_sensor,
  input  logic ped_button,
  input  logic ped_served,
  output logic ns_density,
  output logic ew_density,
  output logic ped_req
`ifdef SENSOR_FAULT_EN
  , output logic ns_fault
  , output logic ew_fault
`endif
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int WC_W = $clog2(WINDOW);
  localparam logic [DB_W-1:0]  DB_TOP  = DB_W'(DEBOUNCE - 1);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HI_V    = CNT_W'(HIGH_TH);
  localparam logic [CNT_W-1:0] LO_V    = CNT_W'(LOW_TH);

  typedef enum logic {IDLE, PENDING} ped_state_t;

  // Bit 0 = NS lane, bit 1 = EW lane, bit 2 = pedestrian button.
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]       deb_q, deb_d, rise;
  logic [DB_W-1:0]  dcnt_q [3];
  logic [DB_W-1:0]  dcnt_d [3];
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] vcnt_q [2];
  logic [CNT_W-1:0] vcnt_d [2];
  logic [CNT_W-1:0] vfinal [2];
  logic [1:0]       dens_q, dens_d;
  logic             win_end;
  ped_state_t       ped_q, ped_d;

`ifdef SENSOR_FAULT_EN
  localparam int ST_W = $clog2(STUCK_TIME + 1);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STUCK_TIME);
  logic [ST_W-1:0] stuck_q [2];
  logic [ST_W-1:0] stuck_d [2];
  logic [1:0]      fault_q, fault_d;
`endif

  always_comb begin
    sync1_d = {ped_button, ew_sensor, ns_sensor};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DB_TOP) deb_d[i] = sync2_q[i];
        else                     dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
    rise = deb_d & ~deb_q;
  end

  always_comb begin
    win_end = (wcnt_q == WC_LAST);
    wcnt_d  = win_end ? '0 : wcnt_q + 1'b1;
    dens_d  = dens_q;
`ifdef SENSOR_FAULT_EN
    fault_d = fault_q;
`endif
    for (int l = 0; l < 2; l++) begin
      // An event on the closing edge still belongs to the closing window.
      vfinal[l] = (rise[l] && (vcnt_q[l] != CNT_MAX)) ? vcnt_q[l] + 1'b1 : vcnt_q[l];
      vcnt_d[l] = win_end ? '0 : vfinal[l];
      if (win_end) begin
        if (vfinal[l] >= HI_V)      dens_d[l] = 1'b1;
        else if (vfinal[l] <= LO_V) dens_d[l] = 1'b0;
`ifdef SENSOR_FAULT_EN
        if (fault_q[l]) dens_d[l] = 1'b1;
`endif
      end
`ifdef SENSOR_FAULT_EN
      stuck_d[l] = !deb_q[l] ? '0 :
                   (stuck_q[l] == ST_MAX) ? stuck_q[l] : stuck_q[l] + 1'b1;
      fault_d[l] = deb_d[l] && (fault_q[l] || (stuck_d[l] == ST_MAX));
`endif
    end
  end

  always_comb begin
    ped_d = ped_q;
    case (ped_q)
      IDLE:    if (rise[2] && !ped_served) ped_d = PENDING;
      PENDING: if (ped_served)             ped_d = IDLE;
      default: ped_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      dcnt_q  <= '{default: '0};
      wcnt_q  <= '0;
      vcnt_q  <= '{default: '0};
      dens_q  <= '0;
      ped_q   <= IDLE;
`ifdef SENSOR_FAULT_EN
      stuck_q <= '{default: '0};
      fault_q <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      wcnt_q  <= wcnt_d;
      vcnt_q  <= vcnt_d;
      dens_q  <= dens_d;
      ped_q   <= ped_d;
`ifdef SENSOR_FAULT_EN
      stuck_q <= stuck_d;
      fault_q <= fault_d;
`endif
    end
  end

  assign ns_density = dens_q[0];
  assign ew_density = dens_q[1];
  assign ped_req    = (ped_q == PENDING);
`ifdef SENSOR_FAULT_EN
  assign ns_fault = fault_q[0];
  assign ew_fault = fault_q[1];
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: window-level density table with an expected-result queue,
// plus hand sequences for pedestrian latch, boundary events, saturation and mid-window reset.
module tb_traffic_sensor_conditioner;
  localparam int W = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ns_sensor = 1'b0, ew_sensor = 1'b0, ped_button = 1'b0, ped_served = 1'b0;
  logic ns_d, ew_d, pr;
  logic s_ns, s_ew, s_pr;
`ifdef SENSOR_FAULT_EN
  logic ns_f, ew_f, s_nsf, s_ewf;
`endif

  always #5 clk = ~clk;

  traffic_sensor_conditioner dut (
    .clk(clk), .reset(reset), .ns_sensor(ns_sensor), .ew_sensor(ew_sensor),
    .ped_button(ped_button), .ped_served(ped_served),
    .ns_density(ns_d), .ew_density(ew_d), .ped_req(pr)
`ifdef SENSOR_FAULT_EN
    , .ns_fault(ns_f), .ew_fault(ew_f)
`endif
  );

  traffic_sensor_conditioner #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .ns_sensor(ns_sensor), .ew_sensor(ew_sensor),
    .ped_button(ped_button), .ped_served(ped_served),
    .ns_density(s_ns), .ew_density(s_ew), .ped_req(s_pr)
`ifdef SENSOR_FAULT_EN
    , .ns_fault(s_nsf), .ew_fault(s_ewf)
`endif
  );

  typedef struct packed { logic ns; logic ew; } exp_t;
  typedef struct { int nsn; int ewn; logic nse; logic ewe; } vec_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   n_cmp = 0, n_bad = 0, wnum = 0;
  int   ecount = 0;
  logic prev_ns = 1'b0, prev_ew = 1'b0;

  // Edges since reset release; ecount % W is the expected window position.
  always @(posedge clk) ecount <= reset ? 0 : ecount + 1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (window %0d, edge %0d): got %b expected %b", name, wnum, ecount, act, exp);
    end
  endtask

  task automatic close_window();
    exp_t e;
    int guard = 0;
    while ((ecount % W) != W - 1 && guard < 2 * W) begin
      step();
      guard++;
    end
    if (guard >= 2 * W) begin
      n_cmp++; n_bad++;
      $display("FAIL window_timeout: got no window end expected one within %0d edges", 2 * W);
    end
    check("pre_end_ns", ns_d, prev_ns);
    check("pre_end_ew", ew_d, prev_ew);
    step();
    wnum++;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got no queued result expected one");
    end else begin
      e = sb.pop_front();
      check("win_ns", ns_d, e.ns);
      check("win_ew", ew_d, e.ew);
      prev_ns = e.ns;
      prev_ew = e.ew;
    end
  endtask

  task automatic run_window(input int nsn, input int ewn, input logic nse, input logic ewe,
                            input int hi, input int lo);
    sb.push_back(exp_t'{ns: nse, ew: ewe});
    for (int k = 0; k < ((nsn > ewn) ? nsn : ewn); k++) begin
      ns_sensor = (k < nsn);
      ew_sensor = (k < ewn);
      repeat (hi) step();
      ns_sensor = 1'b0;
      ew_sensor = 1'b0;
      repeat (lo) step();
    end
    close_window();
  endtask

  task automatic align();
    int guard = 0;
    while ((ecount % W) != 0 && guard < 2 * W) begin
      step();
      guard++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{7, 0, 1'b1, 1'b0};
    tbl[1] = '{5, 2, 1'b1, 1'b0};
    tbl[2] = '{2, 6, 1'b0, 1'b1};
    tbl[3] = '{3, 4, 1'b0, 1'b1};
    tbl[4] = '{4, 3, 1'b0, 1'b0};
    tbl[5] = '{6, 7, 1'b1, 1'b1};
    tbl[6] = '{0, 0, 1'b0, 1'b0};

    repeat (3) step();
    check("rst_ns", ns_d, 1'b0);
    check("rst_ew", ew_d, 1'b0);
    check("rst_ped", pr, 1'b0);
    check("rst_ped_sat", s_pr, 1'b0);
    reset = 1'b0;

    // Pedestrian latch
    ped_button = 1'b1;
    repeat (5) step();
    check("ped_before_rise", pr, 1'b0);
    step();
    check("ped_rise", pr, 1'b1);
    repeat (4) step();
    ped_button = 1'b0;
    repeat (20) step();
    check("ped_hold", pr, 1'b1);
    ped_button = 1'b1;
    repeat (10) step();
    check("ped_repress", pr, 1'b1);
    ped_button = 1'b0;
    repeat (8) step();
    ped_served = 1'b1;
    step();
    check("ped_clear", pr, 1'b0);
    ped_button = 1'b1;
    repeat (10) step();
    check("ped_press_served", pr, 1'b0);
    ped_button = 1'b0;
    repeat (8) step();
    ped_served = 1'b0;
    step();
    check("ped_after_served", pr, 1'b0);
    ped_button = 1'b1;
    repeat (6) step();
    check("ped_rise2", pr, 1'b1);
    ped_button = 1'b0;
    repeat (8) step();
    ped_button = 1'b1;
    repeat (5) step();
    ped_served = 1'b1;
    step();
    check("ped_simul_clear", pr, 1'b0);
    ped_served = 1'b0;
    repeat (5) step();
    check("ped_no_relatch", pr, 1'b0);
    ped_button = 1'b0;
    repeat (8) step();

    // Glitches and a long hold: 1 long + 4 clean events = 5, density holds 0
    align();
    sb.push_back(exp_t'{ns: 1'b0, ew: 1'b0});
    repeat (3) begin
      ns_sensor = 1'b1; repeat (3) step();
      ns_sensor = 1'b0; repeat (4) step();
    end
    ns_sensor = 1'b1; repeat (20) step();
    ns_sensor = 1'b0; repeat (6) step();
    for (int k = 0; k < 4; k++) begin
      ns_sensor = 1'b1; repeat (6) step();
      ns_sensor = 1'b0; repeat (6) step();
    end
    close_window();

    for (int i = 0; i < 7; i++)
      run_window(tbl[i].nsn, tbl[i].ewn, tbl[i].nse, tbl[i].ewe, 6, 6);

    // 10 events: saturating 3-bit counter reads 7 (heavy); a wrapping one would read 2
    run_window(10, 0, 1'b1, 1'b0, 5, 4);
    check("sat_cntw3_ns", s_ns, 1'b1);
    check("sat_cntw3_ew", s_ew, 1'b0);
    run_window(0, 0, 1'b0, 1'b0, 6, 6);

    // NS 6th event lands on the closing edge; EW 6th event lands one edge later
    sb.push_back(exp_t'{ns: 1'b1, ew: 1'b0});
    for (int k = 0; k < 5; k++) begin
      ns_sensor = 1'b1; ew_sensor = 1'b1; repeat (6) step();
      ns_sensor = 1'b0; ew_sensor = 1'b0; repeat (6) step();
    end
    while ((ecount % W) != W - 6) step();
    ns_sensor = 1'b1;
    step();
    ew_sensor = 1'b1;
    close_window();
    repeat (3) step();
    ns_sensor = 1'b0;
    ew_sensor = 1'b0;
    repeat (8) step();
    run_window(3, 5, 1'b0, 1'b1, 6, 6);

    // Reset in mid-window with counts, ew density and ped request all live
    ped_button = 1'b1;
    repeat (6) step();
    check("pre_reset_ped", pr, 1'b1);
    ped_button = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ns_sensor = 1'b1; repeat (6) step();
      ns_sensor = 1'b0; repeat (6) step();
    end
    reset = 1'b1;
    step();
    check("midrst_ns", ns_d, 1'b0);
    check("midrst_ew", ew_d, 1'b0);
    check("midrst_ped", pr, 1'b0);
    repeat (2) step();
    reset = 1'b0;
    prev_ns = 1'b0;
    prev_ew = 1'b0;
    run_window(4, 6, 1'b0, 1'b1, 6, 6);

`ifdef SENSOR_FAULT_EN
    run_window(0, 0, 1'b0, 1'b0, 6, 6);
    ew_sensor = 1'b1;
    repeat (505) step();
    check("fault_before", ew_f, 1'b0);
    step();
    check("fault_set", ew_f, 1'b1);
    check("fault_ns_clear", ns_f, 1'b0);
    check("fault_density_wait", ew_d, 1'b0);
    align();
    check("fault_density", ew_d, 1'b1);
    ew_sensor = 1'b0;
    repeat (5) step();
    check("fault_held", ew_f, 1'b1);
    step();
    check("fault_release", ew_f, 1'b0);
`endif

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
